// File: rtl/sram_pkg.sv
// sram_pkg: shared constants and helpers for SRAM-based FIFOs
//   OB_DEPTH    entries in the output buffer that hides the SRAM read latency
//   clog2_safe  ceil(log2(n)), never below 1 so degenerate sizes still give a legal width
package sram_pkg;
    localparam int OB_DEPTH = 2;
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/sram_fifo_fwft_if.sv
// sram_fifo_fwft_if: handshake bundle of the FWFT FIFO
//   flush                         synchronous clear request
//   in_valid/in_ready/in_data     write side
//   out_valid/out_ready/out_data  read side, head word always presented
//   level/afull                   occupancy status
//   master: the FIFO user, slave: the FIFO
interface sram_fifo_fwft_if #(
    parameter int WIDTH = 64,
    parameter int LW    = 10
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [LW-1:0]    level;
    logic             afull;
    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, level, afull
    );
    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, level, afull
    );
endinterface

// File: rtl/xilinx_1w1r_sram.sv
// xilinx_1w1r_sram: simple dual-port SRAM, port A reads, port B writes
//   clka/cena/aa/qa  read port, cena active-low, qa valid the cycle after the read
//   clkb/cenb/ab/db  write port, cenb active-low
//   Contents are never reset.
module xilinx_1w1r_sram #(
    parameter int WWORD = 64,
    parameter int WADDR = 9,
    parameter int DEPTH = 512
) (
    input  logic             clka,
    input  logic             cena,
    input  logic [WADDR-1:0] aa,
    output logic [WWORD-1:0] qa,
    input  logic             clkb,
    input  logic             cenb,
    input  logic [WADDR-1:0] ab,
    input  logic [WWORD-1:0] db
);
    logic [WWORD-1:0] r_mem [DEPTH];
    always_ff @(posedge clka) begin
        if (!cena) qa <= r_mem[aa];
    end
    always_ff @(posedge clkb) begin
        if (!cenb) r_mem[ab] <= db;
    end
endmodule

// File: rtl/sram_fifo_fwft.sv
// sram_fifo_fwft: first-word-fall-through FIFO over one 1W1R SRAM with a 2-entry output buffer
//   clk  single clock for the FIFO and both SRAM ports
//   rst  synchronous active-high reset
//   bus  slave side of sram_fifo_fwft_if (flush, write/read handshakes, level, afull)
//   Any DEPTH >= 2 works: pointers wrap by explicit compare. Maximum level is DEPTH+2.
module sram_fifo_fwft
    import sram_pkg::*;
#(
    parameter  int WIDTH    = 64,
    parameter  int DEPTH    = 512,
    parameter  int AFULL_TH = DEPTH - 4,
    localparam int AW       = clog2_safe(DEPTH),
    localparam int LW       = clog2_safe(DEPTH + 3)
) (
    input logic clk,
    input logic rst,
    sram_fifo_fwft_if.slave bus
);
    localparam int            CW       = AW + 1;
    localparam logic [CW-1:0] MEM_FULL = CW'(DEPTH);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_mem_cnt;
    logic             r_rd_pend;
    logic [1:0]       r_ob_cnt;
    logic [WIDTH-1:0] r_ob0;
    logic [WIDTH-1:0] r_ob1;
    logic [LW-1:0]    r_level;
    logic             r_afull;

    logic             w_clr;
    logic             w_push;
    logic             w_pop;
    logic             w_issue;
    logic [1:0]       w_ob_kept;
    logic [2:0]       w_ob_claim;
    logic [WIDTH-1:0] w_qa;
    logic [WIDTH-1:0] w_ob0_n;
    logic [WIDTH-1:0] w_ob1_n;
    logic [LW-1:0]    w_level_n;

    assign w_clr        = rst || bus.flush;
    assign bus.in_ready = !w_clr && (r_mem_cnt != MEM_FULL);
    assign w_push       = bus.in_valid && bus.in_ready;
    assign w_pop        = bus.out_valid && bus.out_ready;

    // Entries left after this cycle's pop, plus the slot already claimed by a read in flight.
    // A new read is issued only if its word is guaranteed a free slot when it returns.
    assign w_ob_kept  = r_ob_cnt - {1'b0, w_pop};
    assign w_ob_claim = {1'b0, w_ob_kept} + {2'b00, r_rd_pend};
    assign w_issue    = !w_clr && (r_mem_cnt != '0) && (w_ob_claim < 3'(OB_DEPTH));

    // Returning read data lands right behind the surviving entries; a pop shifts entry 1 down.
    assign w_ob0_n = (r_rd_pend && w_ob_kept == 2'd0) ? w_qa : (w_pop ? r_ob1 : r_ob0);
    assign w_ob1_n = (r_rd_pend && w_ob_kept == 2'd1) ? w_qa : r_ob1;

    assign w_level_n = r_level + LW'(w_push) - LW'(w_pop);

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_mem_cnt <= '0;
            r_rd_pend <= 1'b0;
            r_ob_cnt  <= '0;
            r_ob0     <= '0;
            r_ob1     <= '0;
            r_level   <= '0;
            r_afull   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + AW'(1);
            if (w_issue) r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + AW'(1);
            r_mem_cnt <= r_mem_cnt + CW'(w_push) - CW'(w_issue);
            r_rd_pend <= w_issue;
            r_ob_cnt  <= w_ob_kept + {1'b0, r_rd_pend};
            r_ob0     <= w_ob0_n;
            r_ob1     <= w_ob1_n;
            r_level   <= w_level_n;
            r_afull   <= w_level_n >= LW'(AFULL_TH);
        end
    end

    xilinx_1w1r_sram #(
        .WWORD(WIDTH),
        .WADDR(AW),
        .DEPTH(DEPTH)
    ) u_sram (
        .clka(clk),
        .cena(!w_issue),
        .aa  (r_rd_ptr),
        .qa  (w_qa),
        .clkb(clk),
        .cenb(!w_push),
        .ab  (r_wr_ptr),
        .db  (bus.in_data)
    );

    assign bus.out_valid = r_ob_cnt != 2'd0;
    assign bus.out_data  = r_ob0;
    assign bus.level     = r_level;
    assign bus.afull     = r_afull;
endmodule

// File: tb/tb_sram_fifo_fwft.sv
// tb_sram_fifo_fwft: directed bench for sram_fifo_fwft (DEPTH=12, WIDTH=12) with a queue-based reference
module tb_sram_fifo_fwft;
    localparam int W  = 12;
    localparam int D  = 12;
    localparam int TH = D - 4;
    localparam int LW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    bit   armed = 1'b0;
    logic [W-1:0] q[$];
    int   qt[$];

    sram_fifo_fwft_if #(.WIDTH(W), .LW(LW)) bus ();

    sram_fifo_fwft #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        repeat (n) step();
        rst = 1'b0;
    endtask

    // Reference: every accepted, unpopped word sits in q; the head becomes visible
    // three cycles after it was accepted and stays until popped.
    always @(negedge clk) begin
        bit ev;
        ev = (q.size() != 0) && (qt[0] <= cyc - 3);
        if (rst || bus.flush) chk("in_ready_clr", int'(bus.in_ready), 0);
        if (armed) begin
            chk("level", int'(bus.level), q.size());
            chk("afull", int'(bus.afull), int'(q.size() >= TH));
            chk("out_valid", int'(bus.out_valid), int'(ev));
            if (ev) chk("out_data", int'(bus.out_data), int'(q[0]));
            if (!rst && !bus.flush && q.size() < D) chk("in_ready_room", int'(bus.in_ready), 1);
            if (q.size() >= D + 2) chk("in_ready_full", int'(bus.in_ready), 0);
        end
        if (rst || bus.flush) begin
            q.delete();
            qt.delete();
        end else begin
            if (ev && bus.out_ready) begin
                void'(q.pop_front());
                void'(qt.pop_front());
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(bus.in_data);
                qt.push_back(cyc);
            end
        end
        if (rst) armed = 1'b1;
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        int nxt;
        int nout;
        int sent;
        bus.in_data = '0;

        // Latency and reset values
        do_reset(4);
        bus.in_valid = 1'b1;
        bus.in_data = W'(12'h0A5);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("rst_level", int'(bus.level), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_afull", int'(bus.afull), 0);
        chk("rst_out_data", int'(bus.out_data), 0);
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("lat_level_c1", int'(bus.level), 1);
        chk("lat_valid_c1", int'(bus.out_valid), 0);
        step();
        @(negedge clk);
        chk("lat_valid_c2", int'(bus.out_valid), 0);
        step();
        @(negedge clk);
        chk("lat_valid_c3", int'(bus.out_valid), 1);
        chk("lat_data_c3", int'(bus.out_data), 'hA5);
        step();
        @(negedge clk);
        chk("lat_level_c4", int'(bus.level), 0);
        chk("lat_valid_c4", int'(bus.out_valid), 0);

        // Fill with no reader, then drain in order
        do_reset(2);
        acc = 0;
        for (int i = 0; i < 21; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = W'(i);
            @(negedge clk);
            if (bus.in_ready) acc++;
            step();
        end
        bus.in_valid = 1'b0;
        chk("fill_accepted", acc, 14);
        repeat (2) step();
        @(negedge clk);
        chk("fill_level", int'(bus.level), 14);
        chk("fill_in_ready", int'(bus.in_ready), 0);
        chk("fill_afull", int'(bus.afull), 1);
        step();
        bus.out_ready = 1'b1;
        nxt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                chk("drain_word", int'(bus.out_data), nxt);
                nxt++;
            end
            step();
        end
        chk("drain_count", nxt, 14);

        // Streaming at full rate
        do_reset(2);
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        nout = 0;
        for (int i = 0; i < 1000; i++) begin
            bus.in_data = W'($urandom);
            @(negedge clk);
            if (i >= 10 && i % 100 == 10) chk("tp_level", int'(bus.level), 3);
            if (bus.out_valid) nout++;
            step();
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.out_valid) nout++;
            step();
        end
        chk("tp_count", nout, 1000);

        // Random backpressure with a mid-run reset and flush
        do_reset(2);
        for (int i = 0; i < 600; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data = W'($urandom);
            bus.out_ready = ($urandom_range(0, 9) < 3);
            rst = (i == 300);
            bus.flush = (i == 450);
            step();
        end
        rst = 1'b0;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (30) step();
        @(negedge clk);
        chk("bp_drained", int'(bus.level), 0);

        // Pointer wrap, 100 words through a 12-entry SRAM
        do_reset(2);
        sent = 0;
        nxt = 100;
        for (int c = 0; c < 400 && sent < 100; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data = W'(sent + 100);
            bus.out_ready = (c % 3) != 0;
            @(negedge clk);
            if (bus.in_ready) sent++;
            if (bus.out_valid && bus.out_ready) begin
                chk("wrap_word", int'(bus.out_data), nxt);
                nxt++;
            end
            step();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                chk("wrap_word", int'(bus.out_data), nxt);
                nxt++;
            end
            step();
        end
        chk("wrap_sent", sent, 100);
        chk("wrap_count", nxt, 200);

        // Flush with a read in flight
        do_reset(2);
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data = W'(i + 1);
            step();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        bus.flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = W'(12'h055);
        @(negedge clk);
        chk("fl_level_before", int'(bus.level), 7);
        step();
        bus.flush = 1'b0;
        bus.in_data = W'(12'h03C);
        @(negedge clk);
        chk("fl_level_after", int'(bus.level), 0);
        chk("fl_valid_after", int'(bus.out_valid), 0);
        step();
        bus.in_valid = 1'b0;
        step();
        @(negedge clk);
        chk("fl_valid_c12", int'(bus.out_valid), 0);
        step();
        @(negedge clk);
        chk("fl_valid_c13", int'(bus.out_valid), 1);
        chk("fl_data_c13", int'(bus.out_data), 'h3C);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
